// File: rtl/cpu_controller.sv
// Purpose: Moore control FSM for the 16-bit RISC datapath. It fetches into IR, decodes, and sequences the datapath strobes.
// Latency: one state per cycle; 5 to 10 cycles per instruction plus RST. All outputs decode from state and IR only.
// Flow control: none. Memory is assumed ready; HALT is left only through reset_n. Optional macro: CTRL_ILLEGAL_TRAP_EN.
module cpu_controller #(
    parameter logic [1:0] MNONE  = 2'b00,
    parameter logic [1:0] MREAD  = 2'b01,
    parameter logic [1:0] MWRITE = 2'b10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] mem_rdata,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8,
    output logic        load_pc,
    output logic        reset_pc,
    output logic        addr_sel,
    output logic        load_addr,
    output logic [1:0]  mem_cmd,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPD_PC, S_DECODE, S_WR_IMM,
        S_GET_A, S_GET_B, S_EXEC, S_WR_REG, S_MADDR, S_LADDR,
        S_LDR_RD, S_LDR_WB, S_STR_B, S_STR_C, S_STR_WR, S_HALT
    } state_t;

    state_t      state;
    state_t      dec_next;
    logic [15:0] ir;
    logic        legal;

    wire [2:0] opcode = ir[15:13];
    wire [1:0] op     = ir[12:11];
    wire [2:0] rn     = ir[10:8];
    wire [2:0] rd     = ir[7:5];
    wire [1:0] sh     = ir[4:3];
    wire [2:0] rm     = ir[2:0];

    wire is_cmp  = (opcode == 3'b101) && (op == 2'b01);
    wire is_mem  = (opcode == 3'b011) || (opcode == 3'b100);

    // Immediates track IR directly; they settle once IR is loaded at the end of IF2.
    assign sximm5   = {{11{ir[4]}}, ir[4:0]};
    assign sximm8   = {{8{ir[7]}}, ir[7:0]};
    assign writenum = readnum;

    // Decode the IR into the first execute state, flagging encodings outside the ISA.
    always_comb begin
        legal    = 1'b1;
        dec_next = S_IF1;
        case (opcode)
            3'b110: begin
                if (op == 2'b10)      dec_next = S_WR_IMM;
                else if (op == 2'b00) dec_next = S_GET_B;
                else                  legal    = 1'b0;
            end
            3'b101:                   dec_next = (op == 2'b11) ? S_GET_B : S_GET_A;
            3'b011, 3'b100: begin
                if (op == 2'b00)      dec_next = S_GET_A;
                else                  legal    = 1'b0;
            end
            3'b111:                   dec_next = S_HALT;
            default:                  legal    = 1'b0;
        endcase
        if (!legal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            dec_next = S_HALT;
`else
            dec_next = S_IF1;
`endif
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic ill_q;

    // Sticky trap flag. It is set by an illegal decode and cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                         ill_q <= 1'b0;
        else if (state == S_DECODE && !legal) ill_q <= 1'b1;
    end

    assign illegal = ill_q;
`else
    assign illegal = 1'b0;
`endif

    // State sequencing and instruction-register capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_RST;
            ir    <= '0;
        end else begin
            case (state)
                S_RST:    state <= S_IF1;
                S_IF1:    state <= S_IF2;
                S_IF2: begin
                    ir    <= mem_rdata;
                    state <= S_UPD_PC;
                end
                S_UPD_PC: state <= S_DECODE;
                S_DECODE: state <= dec_next;
                S_WR_IMM: state <= S_IF1;
                S_GET_A:  state <= is_mem ? S_MADDR : S_GET_B;
                S_GET_B:  state <= S_EXEC;
                S_EXEC:   state <= is_cmp ? S_IF1 : S_WR_REG;
                S_WR_REG: state <= S_IF1;
                S_MADDR:  state <= S_LADDR;
                S_LADDR:  state <= (opcode == 3'b011) ? S_LDR_RD : S_STR_B;
                S_LDR_RD: state <= S_LDR_WB;
                S_LDR_WB: state <= S_IF1;
                S_STR_B:  state <= S_STR_C;
                S_STR_C:  state <= S_STR_WR;
                S_STR_WR: state <= S_IF1;
                S_HALT:   state <= S_HALT;
                default:  state <= S_RST;
            endcase
        end
    end

    // Moore output decode. Anything not driven for a state stays 0.
    always_comb begin
        readnum   = 3'd0;
        write     = 1'b0;
        vsel      = 2'b00;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        shift     = 2'b00;
        ALUop     = 2'b00;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        addr_sel  = 1'b0;
        load_addr = 1'b0;
        mem_cmd   = MNONE;
        halted    = 1'b0;
        case (state)
            S_RST: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
            end
            S_IF1, S_IF2: begin
                addr_sel = 1'b1;
                mem_cmd  = MREAD;
            end
            S_UPD_PC: load_pc = 1'b1;
            S_WR_IMM: begin
                readnum = rn;
                vsel    = 2'b10;
                write   = 1'b1;
            end
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                shift = sh;
                ALUop = op;
                asel  = (opcode == 3'b110);
                loads = is_cmp;
                loadc = !is_cmp;
            end
            S_WR_REG: begin
                readnum = rd;
                write   = 1'b1;
            end
            S_MADDR: begin
                bsel  = 1'b1;
                loadc = 1'b1;
            end
            S_LADDR:  load_addr = 1'b1;
            S_LDR_RD: mem_cmd = MREAD;
            S_LDR_WB: begin
                mem_cmd = MREAD;
                readnum = rd;
                vsel    = 2'b11;
                write   = 1'b1;
            end
            S_STR_B: begin
                readnum = rd;
                loadb   = 1'b1;
            end
            S_STR_C: begin
                asel  = 1'b1;
                loadc = 1'b1;
            end
            S_STR_WR: mem_cmd = MWRITE;
            S_HALT:   halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: per-instruction expected strobe vectors, one per cycle, sampled on the falling edge.
// Each test task starts with the controller about to enter IF1 on the next falling-edge sample.
// Tracks the CTRL_ILLEGAL_TRAP_EN build through the same macro.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] mem_rdata;
    logic [2:0]  readnum, writenum;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  vsel, shift, ALUop, mem_cmd;
    logic [15:0] sximm5, sximm8;
    logic        load_pc, reset_pc, addr_sel, load_addr, halted, illegal;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic [1:0] vsel;
        logic       loada, loadb, loadc, loads, asel, bsel;
        logic [1:0] shift;
        logic [1:0] alu_op;
        logic       load_pc, reset_pc, addr_sel, load_addr;
        logic [1:0] mem_cmd;
        logic       halted, illegal;
    } ctl_t;

    cpu_controller dut (
        .clk(clk), .reset_n(reset_n), .mem_rdata(mem_rdata),
        .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
        .sximm5(sximm5), .sximm8(sximm8), .load_pc(load_pc), .reset_pc(reset_pc),
        .addr_sel(addr_sel), .load_addr(load_addr), .mem_cmd(mem_cmd),
        .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic ctl_t observe();
        ctl_t o;
        o.readnum = readnum;   o.writenum = writenum; o.write = write; o.vsel = vsel;
        o.loada = loada;       o.loadb = loadb;       o.loadc = loadc; o.loads = loads;
        o.asel = asel;         o.bsel = bsel;         o.shift = shift; o.alu_op = ALUop;
        o.load_pc = load_pc;   o.reset_pc = reset_pc; o.addr_sel = addr_sel;
        o.load_addr = load_addr; o.mem_cmd = mem_cmd; o.halted = halted; o.illegal = illegal;
        return o;
    endfunction

    // Expected vectors for IF1, IF2, UPD_PC, DECODE.
    function automatic ctl_t v_fetch(input int i);
        ctl_t v = '0;
        if (i < 2) begin
            v.addr_sel = 1'b1;
            v.mem_cmd  = 2'b01;
        end else if (i == 2) begin
            v.load_pc = 1'b1;
        end
        return v;
    endfunction

    function automatic ctl_t v_rst();
        ctl_t v = '0;
        v.reset_pc = 1'b1;
        v.load_pc  = 1'b1;
        return v;
    endfunction

    function automatic ctl_t v_reg(input logic [2:0] r);
        ctl_t v = '0;
        v.readnum  = r;
        v.writenum = r;
        return v;
    endfunction

    task automatic test_reset();
        ctl_t o;
        reset_n   = 1'b0;
        mem_rdata = 16'h0000;
        repeat (2) @(negedge clk);
        o = observe();
        vectors++;
        if (o !== v_rst()) begin
            miscompares++;
            $display("FAIL reset_state got %h expected %h", o, v_rst());
        end
        vectors++;
        if (sximm8 !== 16'h0000 || sximm5 !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_ir got sximm8=%h sximm5=%h expected 0000", sximm8, sximm5);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_mov_imm(input logic [15:0] instr, input logic [2:0] rn, input logic [15:0] imm8);
        ctl_t e[$];
        ctl_t o;
        ctl_t v;
        for (int i = 0; i < 4; i++) e.push_back(v_fetch(i));
        v = v_reg(rn); v.vsel = 2'b10; v.write = 1'b1; e.push_back(v);
        mem_rdata = instr;
        for (int i = 0; i < e.size(); i++) begin
            @(negedge clk);
            o = observe();
            vectors++;
            if (o !== e[i]) begin
                miscompares++;
                $display("FAIL mov_imm %h cycle %0d got %h expected %h", instr, i, o, e[i]);
            end
        end
        vectors++;
        if (sximm8 !== imm8) begin
            miscompares++;
            $display("FAIL mov_imm %h sximm8 got %h expected %h", instr, sximm8, imm8);
        end
    endtask

    task automatic test_alu();
        ctl_t e[$];
        ctl_t o;
        ctl_t v;
        // ADD R5,R2,R1
        for (int i = 0; i < 4; i++) e.push_back(v_fetch(i));
        v = v_reg(3'd2); v.loada = 1'b1; e.push_back(v);
        v = v_reg(3'd1); v.loadb = 1'b1; e.push_back(v);
        v = '0; v.loadc = 1'b1; e.push_back(v);
        v = v_reg(3'd5); v.write = 1'b1; e.push_back(v);
        // CMP R2,R1
        for (int i = 0; i < 4; i++) e.push_back(v_fetch(i));
        v = v_reg(3'd2); v.loada = 1'b1; e.push_back(v);
        v = v_reg(3'd1); v.loadb = 1'b1; e.push_back(v);
        v = '0; v.loads = 1'b1; v.alu_op = 2'b01; e.push_back(v);
        // MOV R3,R4,sh=01
        for (int i = 0; i < 4; i++) e.push_back(v_fetch(i));
        v = v_reg(3'd4); v.loadb = 1'b1; e.push_back(v);
        v = '0; v.asel = 1'b1; v.shift = 2'b01; v.loadc = 1'b1; e.push_back(v);
        v = v_reg(3'd3); v.write = 1'b1; e.push_back(v);
        // MVN R6,R7,sh=10
        for (int i = 0; i < 4; i++) e.push_back(v_fetch(i));
        v = v_reg(3'd7); v.loadb = 1'b1; e.push_back(v);
        v = '0; v.shift = 2'b10; v.alu_op = 2'b11; v.loadc = 1'b1; e.push_back(v);
        v = v_reg(3'd6); v.write = 1'b1; e.push_back(v);
        mem_rdata = 16'hA2A1;
        for (int i = 0; i < e.size(); i++) begin
            @(negedge clk);
            if (i == 8)  mem_rdata = 16'hAA01;
            if (i == 15) mem_rdata = 16'hC06C;
            if (i == 22) mem_rdata = 16'hB8D7;
            o = observe();
            vectors++;
            if (o !== e[i]) begin
                miscompares++;
                $display("FAIL alu_seq cycle %0d got %h expected %h", i, o, e[i]);
            end
        end
    endtask

    task automatic test_ldr_str();
        ctl_t e[$];
        ctl_t o;
        ctl_t v;
        // LDR R2,[R1,#3]
        for (int i = 0; i < 4; i++) e.push_back(v_fetch(i));
        v = v_reg(3'd1); v.loada = 1'b1; e.push_back(v);
        v = '0; v.bsel = 1'b1; v.loadc = 1'b1; e.push_back(v);
        v = '0; v.load_addr = 1'b1; e.push_back(v);
        v = '0; v.mem_cmd = 2'b01; e.push_back(v);
        v = v_reg(3'd2); v.mem_cmd = 2'b01; v.vsel = 2'b11; v.write = 1'b1; e.push_back(v);
        // STR R3,[R0,#1]
        for (int i = 0; i < 4; i++) e.push_back(v_fetch(i));
        v = v_reg(3'd0); v.loada = 1'b1; e.push_back(v);
        v = '0; v.bsel = 1'b1; v.loadc = 1'b1; e.push_back(v);
        v = '0; v.load_addr = 1'b1; e.push_back(v);
        v = v_reg(3'd3); v.loadb = 1'b1; e.push_back(v);
        v = '0; v.asel = 1'b1; v.loadc = 1'b1; e.push_back(v);
        v = '0; v.mem_cmd = 2'b10; e.push_back(v);
        mem_rdata = 16'h6143;
        for (int i = 0; i < e.size(); i++) begin
            @(negedge clk);
            if (i == 5) begin
                vectors++;
                if (sximm5 !== 16'h0003) begin
                    miscompares++;
                    $display("FAIL ldr_sximm5 got %h expected 0003", sximm5);
                end
            end
            if (i == 9) mem_rdata = 16'h8061;
            o = observe();
            vectors++;
            if (o !== e[i]) begin
                miscompares++;
                $display("FAIL ldr_str cycle %0d got %h expected %h", i, o, e[i]);
            end
        end
    endtask

    task automatic test_illegal();
        ctl_t o;
        ctl_t v;
        mem_rdata = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            o = observe();
            vectors++;
            if (o !== v_fetch(i)) begin
                miscompares++;
                $display("FAIL illegal_fetch cycle %0d got %h expected %h", i, o, v_fetch(i));
            end
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        v = '0; v.halted = 1'b1; v.illegal = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            o = observe();
            vectors++;
            if (o !== v) begin
                miscompares++;
                $display("FAIL illegal_trap cycle %0d got %h expected %h", i, o, v);
            end
        end
        reset_n = 1'b0;
        #1;
        o = observe();
        vectors++;
        if (o !== v_rst()) begin
            miscompares++;
            $display("FAIL illegal_reset got %h expected %h", o, v_rst());
        end
        @(negedge clk);
        reset_n = 1'b1;
`else
        v = '0;
        if (v !== '0) $display("unreachable");
`endif
    endtask

    task automatic test_reset_mid_exec();
        ctl_t o;
        ctl_t v;
        mem_rdata = 16'hA2A1;
        repeat (7) @(negedge clk);
        v = '0; v.loadc = 1'b1;
        o = observe();
        vectors++;
        if (o !== v) begin
            miscompares++;
            $display("FAIL exec_before_reset got %h expected %h", o, v);
        end
        reset_n = 1'b0;
        #1;
        o = observe();
        vectors++;
        if (o !== v_rst()) begin
            miscompares++;
            $display("FAIL reset_mid_exec got %h expected %h", o, v_rst());
        end
        vectors++;
        if (sximm8 !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_mid_exec_ir got sximm8=%h expected 0000", sximm8);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_halt();
        ctl_t o;
        ctl_t v;
        mem_rdata = 16'hE000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            o = observe();
            vectors++;
            if (o !== v_fetch(i)) begin
                miscompares++;
                $display("FAIL halt_fetch cycle %0d got %h expected %h", i, o, v_fetch(i));
            end
        end
        v = '0; v.halted = 1'b1;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            o = observe();
            vectors++;
            if (o !== v) begin
                miscompares++;
                $display("FAIL halt_hold cycle %0d got %h expected %h", i, o, v);
            end
        end
        reset_n = 1'b0;
        #1;
        o = observe();
        vectors++;
        if (o !== v_rst()) begin
            miscompares++;
            $display("FAIL halt_reset got %h expected %h", o, v_rst());
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        o = observe();
        vectors++;
        if (o !== v_fetch(0)) begin
            miscompares++;
            $display("FAIL halt_restart got %h expected %h", o, v_fetch(0));
        end
    endtask

    initial begin
        test_reset();
        test_mov_imm(16'hD105, 3'd1, 16'h0005);
        test_mov_imm(16'hD2F0, 3'd2, 16'hFFF0);
        test_alu();
        test_ldr_str();
        test_illegal();
        test_mov_imm(16'hD37F, 3'd3, 16'h007F);
        test_reset_mid_exec();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
